// File: rtl/bsg_skid_pkg.sv
// Shared types for the skid-slice family.
// Also reused by the multi-stage chain wrapper.
package bsg_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bsg_skid_state_e;

    localparam int unsigned bsg_skid_width_lp = 16;

endpackage

// File: rtl/bsg_dff_skid_slice_if.sv
// Handshake bundle for one skid slice: valid/ready upstream, valid/yumi downstream.
interface bsg_dff_skid_slice_if
    import bsg_skid_pkg::*;
#(
    parameter int unsigned width_p = bsg_skid_width_lp
);
    logic [width_p-1:0] data_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               yumi_i;

    modport slave (
        input  data_i, v_i, yumi_i,
        output ready_o, data_o, v_o
    );

    modport master (
        output data_i, v_i, yumi_i,
        input  ready_o, data_o, v_o
    );
endinterface

// File: rtl/bsg_dff_en.sv
// Plain enabled data flop; deliberately has no reset.
module bsg_dff_en #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bsg_dff_skid_slice.sv
// Two-entry elastic slice: main_r drives the output, skid_r absorbs the word that
// arrives while downstream stalls, so ready_o depends only on flops.
module bsg_dff_skid_slice
    import bsg_skid_pkg::*;
#(
    parameter int unsigned width_p = bsg_skid_width_lp
) (
    input logic                 clk_i,
    input logic                 reset_i,
    bsg_dff_skid_slice_if.slave skid_io
);

    bsg_skid_state_e    state_r, state_n;
    logic               reset_r;
    logic               enq, deq;
    logic               main_en, main_from_skid, skid_en;
    logic [width_p-1:0] main_d, skid_r;

    assign skid_io.v_o     = (state_r != EMPTY);
    assign skid_io.ready_o = (state_r != TWO) & ~reset_r;

    assign enq = skid_io.v_i & skid_io.ready_o;
    assign deq = skid_io.yumi_i;

    always_comb begin
        state_n        = state_r;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        unique case (state_r)
            EMPTY: begin
                if (enq) begin
                    state_n = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (enq & ~deq) begin
                    state_n = TWO;
                    skid_en = 1'b1;
                end else if (~enq & deq) begin
                    state_n = EMPTY;
                end else if (enq & deq) begin
                    main_en = 1'b1;
                end
            end
            TWO: begin
                // Oldest pending word moves up; skid_r is never bypassed.
                if (deq) begin
                    state_n        = ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_r : skid_io.data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= EMPTY;
            reset_r <= 1'b1;
        end else begin
            state_r <= state_n;
            reset_r <= 1'b0;
        end
    end

    bsg_dff_en #(
        .width_p (width_p)
    ) main_dff (
        .clk_i  (clk_i),
        .en_i   (main_en),
        .data_i (main_d),
        .data_o (skid_io.data_o)
    );

    bsg_dff_en #(
        .width_p (width_p)
    ) skid_dff (
        .clk_i  (clk_i),
        .en_i   (skid_en),
        .data_i (skid_io.data_i),
        .data_o (skid_r)
    );

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        skid_io.yumi_i |-> skid_io.v_o);

    ctrl_known: assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown({skid_io.v_i, skid_io.yumi_i}));

endmodule

// File: tb/tb_bsg_dff_skid_slice.sv
// Self-checking bench for bsg_dff_skid_slice: directed scenarios plus a queue scoreboard.
module tb_bsg_dff_skid_slice;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] sb_q[$];
    logic        mon_en  = 1'b0;
    logic        rst_prev = 1'b1;

    bsg_dff_skid_slice_if #(.width_p(16)) link ();

    bsg_dff_skid_slice #(
        .width_p (16)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .skid_io (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: mirrors occupancy and data ordering; inputs are stable at negedge.
    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (mon_en) begin
            checks++;
            if (link.v_o !== (sb_q.size() != 0)) begin
                errors++;
                $display("FAIL mon_v_o: got %b want %b", link.v_o, sb_q.size() != 0);
            end
            checks++;
            if (link.ready_o !== ((sb_q.size() < 2) && !rst_prev)) begin
                errors++;
                $display("FAIL mon_ready_o: got %b want %b", link.ready_o,
                         (sb_q.size() < 2) && !rst_prev);
            end
            if (reset) begin
                sb_q.delete();
            end else begin
                if (link.v_o && link.yumi_i) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL mon_deq_empty: got %h want no word", link.data_o);
                    end else begin
                        exp_w = sb_q.pop_front();
                        if (link.data_o !== exp_w) begin
                            errors++;
                            $display("FAIL mon_data: got %h want %h", link.data_o, exp_w);
                        end
                    end
                end
                if (link.v_i && link.ready_o) sb_q.push_back(link.data_i);
            end
        end
        rst_prev = reset;
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (link.v_o !== 1'b0 || link.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got v_o=%b ready_o=%b want 0 0", link.v_o, link.ready_o);
            end
        end
        reset = 1'b0;
        checks++;
        if (link.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: got ready_o=%b want 0", link.ready_o);
        end
        tick();
        checks++;
        if (link.ready_o !== 1'b1 || link.v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready_o=%b v_o=%b want 1 0", link.ready_o, link.v_o);
        end
        link.v_i = 1'b0;
        mon_en   = 1'b1;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 16; i++) begin
            link.v_i    = 1'b1;
            link.data_i = 16'(i);
            link.yumi_i = link.v_o;
            checks++;
            if (link.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, link.ready_o);
            end
            if (i > 1) begin
                checks++;
                if (link.v_o !== 1'b1 || link.data_o !== 16'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_word[%0d]: got v=%b d=%h want v=1 d=%h",
                             i, link.v_o, link.data_o, 16'(i - 1));
                end
            end
            tick();
        end
        link.v_i    = 1'b0;
        link.yumi_i = link.v_o;
        checks++;
        if (link.v_o !== 1'b1 || link.data_o !== 16'h0010) begin
            errors++;
            $display("FAIL stream_last: got v=%b d=%h want v=1 d=0010", link.v_o, link.data_o);
        end
        tick();
        link.yumi_i = 1'b0;
    endtask

    task automatic test_backpressure();
        link.yumi_i = 1'b0;
        link.v_i    = 1'b1;
        link.data_i = 16'hA5A5;
        tick();
        link.data_i = 16'h5A5A;
        tick();
        link.data_i = 16'hFFFF;
        checks++;
        if (link.ready_o !== 1'b0 || link.v_o !== 1'b1 || link.data_o !== 16'hA5A5) begin
            errors++;
            $display("FAIL bp_full: got r=%b v=%b d=%h want r=0 v=1 d=a5a5",
                     link.ready_o, link.v_o, link.data_o);
        end
        tick();
        tick();
        checks++;
        if (link.ready_o !== 1'b0 || link.data_o !== 16'hA5A5) begin
            errors++;
            $display("FAIL bp_hold: got r=%b d=%h want r=0 d=a5a5", link.ready_o, link.data_o);
        end
        link.v_i = 1'b0;
    endtask

    task automatic test_drain();
        link.yumi_i = 1'b1;
        tick();
        checks++;
        if (link.ready_o !== 1'b1 || link.v_o !== 1'b1 || link.data_o !== 16'h5A5A) begin
            errors++;
            $display("FAIL drain_first: got r=%b v=%b d=%h want r=1 v=1 d=5a5a",
                     link.ready_o, link.v_o, link.data_o);
        end
        tick();
        link.yumi_i = 1'b0;
        checks++;
        if (link.v_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got v_o=%b want 0", link.v_o);
        end
    endtask

    task automatic test_simultaneous();
        link.v_i    = 1'b1;
        link.data_i = 16'h1111;
        tick();
        link.data_i = 16'h2222;
        link.yumi_i = 1'b1;
        tick();
        link.v_i = 1'b0;
        checks++;
        if (link.v_o !== 1'b1 || link.data_o !== 16'h2222 || link.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL simul: got v=%b d=%h r=%b want v=1 d=2222 r=1",
                     link.v_o, link.data_o, link.ready_o);
        end
        tick();
        link.yumi_i = 1'b0;
        checks++;
        if (link.v_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got v_o=%b want 0", link.v_o);
        end
    endtask

    task automatic test_mid_reset();
        link.v_i    = 1'b1;
        link.data_i = 16'h0AAA;
        tick();
        link.data_i = 16'h0BBB;
        tick();
        link.v_i = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (link.v_o !== 1'b0 || link.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b r=%b want 0 0", link.v_o, link.ready_o);
        end
        tick();
        link.v_i    = 1'b1;
        link.data_i = 16'h0BEE;
        tick();
        link.v_i = 1'b0;
        checks++;
        if (link.v_o !== 1'b1 || link.data_o !== 16'h0BEE) begin
            errors++;
            $display("FAIL mid_reset_word: got v=%b d=%h want v=1 d=0bee", link.v_o, link.data_o);
        end
        link.yumi_i = 1'b1;
        tick();
        link.yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link.v_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_stale[%0d]: got v=%b d=%h want v=0", i, link.v_o,
                         link.data_o);
            end
            tick();
        end
    endtask

    initial begin
        reset       = 1'b1;
        link.v_i    = 1'b1;
        link.data_i = 16'hDEAD;
        link.yumi_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_simultaneous();
        test_mid_reset();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d words want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
